// File: rtl/bsmodred.sv
// Bit-serial mod-MOD reducer: LEN-bit MSB-first word in, OLEN-bit residue out with osync.
// Latency is LEN cycles from isync to osync. There is no backpressure: a new word may start on any cycle.
module bsmodred #(
    parameter int LEN  = 48,
    parameter int OLEN = 24,
    parameter int MOD  = 29
) (
    input  logic clk,
    input  logic reset,
    input  logic i,
    input  logic isync,
    output logic q,
    output logic osync
);
    localparam int AW = $clog2(MOD) + 1;
    localparam int CW = $clog2(LEN + 1);
    localparam logic [AW:0] MODW = (AW+1)'(MOD);

    typedef enum logic {IDLE, ACC} state_t;

    state_t          state;
    logic [AW-1:0]   r;
    logic [CW-1:0]   cnt;
    logic [OLEN-1:0] sh;
    logic [CW-1:0]   ocnt;

    logic [AW:0]     t;
    logic [AW-1:0]   r_step;
    logic [OLEN-1:0] res;
    logic            last;

    // Horner step: r < MOD keeps 2r+i below 2*MOD, so one subtract suffices.
    always_comb begin
        t      = {r, i};
        r_step = (t >= MODW) ? AW'(t - MODW) : AW'(t);
        res    = OLEN'(r_step);
        last   = (cnt == CW'(LEN - 1));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            r     <= '0;
            cnt   <= '0;
            sh    <= '0;
            ocnt  <= '0;
            q     <= 1'b0;
            osync <= 1'b0;
        end else begin
            osync <= 1'b0;
            if (ocnt != '0) begin
                q    <= sh[OLEN-1];
                sh   <= sh << 1;
                ocnt <= ocnt - CW'(1);
            end else begin
                q <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (isync) begin
                        r     <= {{(AW-1){1'b0}}, i};
                        cnt   <= CW'(1);
                        state <= ACC;
                    end
                end
                ACC: begin
                    if (isync) begin
                        r   <= {{(AW-1){1'b0}}, i};
                        cnt <= CW'(1);
                    end else if (last) begin
                        // Residue MSB goes straight to q; the shifter holds the rest.
                        q     <= res[OLEN-1];
                        osync <= 1'b1;
                        sh    <= res << 1;
                        ocnt  <= CW'(OLEN - 1);
                        r     <= '0;
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        r   <= r_step;
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bsmodred.sv
// Bench for bsmodred: vector table plus hand-written abort/reset sequences, scoreboarded on osync.
module tb_bsmodred;
    localparam int LEN  = 48;
    localparam int OLEN = 24;
    localparam int MOD  = 29;

    logic clk;
    logic reset;
    logic i;
    logic isync;
    logic q;
    logic osync;

    bsmodred #(.LEN(LEN), .OLEN(OLEN), .MOD(MOD)) dut (
        .clk   (clk),
        .reset (reset),
        .i     (i),
        .isync (isync),
        .q     (q),
        .osync (osync)
    );

    typedef struct {
        logic [LEN-1:0]  val;
        logic [OLEN-1:0] exp;
    } vec_t;

    typedef struct {
        logic [OLEN-1:0] exp;
        int              sync_cyc;
        bit              abort;
    } sb_t;

    sb_t sbq[$];
    int  errors = 0;
    int  checks = 0;
    int  cyc    = 0;
    int  pushes = 0;
    int  osync_seen = 0;
    bit  mon_en = 0;
    bit  capturing = 0;
    int  cap_n = 0;
    logic [OLEN-1:0] cap_val;
    sb_t cur;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drives the top nb bits of v, MSB first, isync on the first one.
    task automatic send(input logic [LEN-1:0] v, input int nb, input bit push,
                        input logic [OLEN-1:0] exp, input bit abort);
        sb_t e;
        for (int b = 0; b < nb; b++) begin
            @(posedge clk); #1;
            i     = v[LEN-1-b];
            isync = (b == 0);
            if (b == 0 && push) begin
                e.exp = exp;
                e.sync_cyc = cyc;
                e.abort = abort;
                sbq.push_back(e);
                pushes++;
            end
        end
    endtask

    task automatic idle(input int n, input bit noise);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            i     = noise ? 1'($urandom) : 1'b0;
            isync = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (osync) begin
                osync_seen++;
                check("osync_overlap", capturing, 0);
                if (sbq.size() == 0) begin
                    check("unexpected_osync", 1, 0);
                    capturing = 0;
                end else begin
                    cur = sbq.pop_front();
                    check("latency", cyc - cur.sync_cyc, LEN);
                    cap_val   = {{(OLEN-1){1'b0}}, q};
                    cap_n     = 1;
                    capturing = 1;
                end
            end else if (capturing) begin
                cap_val = {cap_val[OLEN-2:0], q};
                cap_n++;
            end else begin
                check("q_idle", q, 0);
            end
            if (capturing && cap_n == OLEN) begin
                capturing = 0;
                if (cur.abort) check("aborted_word_completed", 1, 0);
                else           check("residue", cap_val, cur.exp);
            end
            if (!reset) capturing = 0;
        end
    end

    initial begin
        vec_t tbl[11];
        logic [LEN-1:0] v;
        longint unsigned lv;
        int waited;

        tbl[0]  = '{48'h10,           24'h000010};
        tbl[1]  = '{48'hFFFFFFFFFFFF, 24'h000016};
        tbl[2]  = '{48'h1D,           24'h000000};
        tbl[3]  = '{48'h3A,           24'h000000};
        tbl[4]  = '{48'h1C,           24'h00001C};
        tbl[5]  = '{48'h1E,           24'h000001};
        tbl[6]  = '{48'h0,            24'h000000};
        tbl[7]  = '{48'h1,            24'h000001};
        tbl[8]  = '{48'h800000000000, 24'h00001A};
        tbl[9]  = '{48'h64,           24'h00000D};
        tbl[10] = '{48'h1F,           24'h000002};

        reset = 1'b0;
        i     = 1'b0;
        isync = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("reset_q", q, 0);
        check("reset_osync", osync, 0);
        mon_en = 1;

        idle(5, 0);
        // Table words back-to-back: isync every LEN cycles.
        for (int n = 0; n < 11; n++)
            send(tbl[n].val, LEN, 1, tbl[n].exp, 0);

        for (int n = 0; n < 6; n++) begin
            v  = {16'($urandom), 32'($urandom)};
            lv = 64'(v);
            send(v, LEN, 1, OLEN'(lv % 64'(MOD)), 0);
        end
        idle(LEN + OLEN + 4, 0);

        // Abort after 20 bits, then 0x64.
        send(48'hABCDEF012345, 20, 0, '0, 0);
        send(48'h64, LEN, 1, 24'h00000D, 0);
        idle(LEN + 4, 0);

        // isync on the would-be last bit aborts the word.
        send(48'hFFFFFFFFFFFF, LEN - 1, 0, '0, 0);
        send(48'h1E, LEN, 1, 24'h000001, 0);
        idle(LEN + OLEN + 4, 0);

        // Reset during residue bit 10 of a word.
        send(48'hFFFFFFFFFFFF, LEN, 1, '0, 1);
        idle(13, 0);
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        check("post_reset_q", q, 0);
        check("post_reset_osync", osync, 0);

        idle(200, 1);
        send(48'h1F, LEN, 1, 24'h000002, 0);
        idle(1, 0);

        waited = 0;
        while ((sbq.size() != 0 || capturing) && waited < 300) begin
            @(posedge clk);
            waited++;
        end
        idle(8, 0);
        check("drain", sbq.size(), 0);
        check("osync_count", osync_seen, pushes);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
